// File: rtl/gray_counter_param_if.sv
// Control/status bundle for the parametrised Gray counter.
// The master side drives count controls; the slave side is the counter itself.
interface gray_counter_param_if #(
  parameter int WIDTH = 3
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] gray_out;
  logic [WIDTH-1:0] bin_out;
  logic             tc;
  logic             wrapped;

  modport master (
    output en, up_dn, load, load_val,
    input  gray_out, bin_out, tc, wrapped
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output gray_out, bin_out, tc, wrapped
  );
endinterface

// File: rtl/gray_counter_param.sv
// Gray-code up/down counter with load, wrap/saturate mode, binary readout,
// terminal-count flag and a registered one-cycle wrap pulse.
module gray_counter_param #(
  parameter int WIDTH = 3,
  parameter int WRAP  = 1
) (
  input logic                 clk,
  input logic                 reset,
  gray_counter_param_if.slave bus
);
  logic [WIDTH-1:0] gray_q;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] bin_nxt;
  logic             tc;
  logic             wrapped_q;

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin = '0;
    for (int i = 0; i < WIDTH; i++) bin[i] = ^(gray_q >> i);
  end

  assign tc      = bus.up_dn ? (&bin) : ~(|bin);
  assign bin_nxt = bus.up_dn ? bin + WIDTH'(1) : bin - WIDTH'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      gray_q    <= '0;
      wrapped_q <= 1'b0;
    end else if (bus.load) begin
      gray_q    <= bus.load_val ^ (bus.load_val >> 1);
      wrapped_q <= 1'b0;
    end else if (bus.en) begin
      // In saturate mode the terminal value is sticky until direction flips.
      if (tc && (WRAP == 0)) begin
        wrapped_q <= 1'b0;
      end else begin
        gray_q    <= bin_nxt ^ (bin_nxt >> 1);
        wrapped_q <= tc;
      end
    end else begin
      wrapped_q <= 1'b0;
    end
  end

  assign bus.gray_out = gray_q;
  assign bus.bin_out  = bin;
  assign bus.tc       = tc;
  assign bus.wrapped  = wrapped_q;
endmodule

// File: tb/tb_gray_counter_param.sv
// Directed bench for gray_counter_param: 3-bit wrap, 4-bit saturate, 8-bit random walk.
module tb_gray_counter_param;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  gray_counter_param_if #(.WIDTH(3)) a3 ();
  gray_counter_param_if #(.WIDTH(4)) a4 ();
  gray_counter_param_if #(.WIDTH(8)) a8 ();

  gray_counter_param #(.WIDTH(3), .WRAP(1)) u3 (.clk(clk), .reset(reset), .bus(a3.slave));
  gray_counter_param #(.WIDTH(4), .WRAP(0)) u4 (.clk(clk), .reset(reset), .bus(a4.slave));
  gray_counter_param #(.WIDTH(8), .WRAP(1)) u8 (.clk(clk), .reset(reset), .bus(a8.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          g3 [9];
    int          m, mw, seen_w, exp_w;
    bit          e, d;
    logic [7:0]  prev_g;

    g3 = '{1, 3, 2, 6, 7, 5, 4, 0, 1};
    reset = 1'b1;
    a3.en = 0; a3.up_dn = 1; a3.load = 0; a3.load_val = '0;
    a4.en = 0; a4.up_dn = 1; a4.load = 0; a4.load_val = '0;
    a8.en = 0; a8.up_dn = 1; a8.load = 0; a8.load_val = '0;

    // 1: reset state, then count up through a wrap
    tick();
    check("rst_gray", a3.gray_out, 0);
    check("rst_bin", a3.bin_out, 0);
    check("rst_tc_up", a3.tc, 0);
    check("rst_wrapped", a3.wrapped, 0);
    reset = 1'b0;
    a3.en = 1;
    for (int k = 0; k < 9; k++) begin
      tick();
      check($sformatf("up_gray%0d", k), a3.gray_out, g3[k]);
      check($sformatf("up_bin%0d", k), a3.bin_out, (k + 1) % 8);
      check($sformatf("up_tc%0d", k), a3.tc, (k == 6) ? 1 : 0);
      check($sformatf("up_wrapped%0d", k), a3.wrapped, (k == 7) ? 1 : 0);
    end

    // 2: reset with down direction, wrap 0 -> max
    reset = 1'b1; a3.en = 0; a3.up_dn = 0;
    tick();
    reset = 1'b0;
    check("rst_tc_dn", a3.tc, 1);
    a3.en = 1;
    tick();
    check("dn_gray0", a3.gray_out, 3'b100);
    check("dn_bin0", a3.bin_out, 7);
    check("dn_wrapped0", a3.wrapped, 1);
    check("dn_tc0", a3.tc, 0);
    tick();
    check("dn_gray1", a3.gray_out, 3'b101);
    check("dn_bin1", a3.bin_out, 6);
    check("dn_wrapped1", a3.wrapped, 0);

    // 3: load wins over en
    a3.up_dn = 1; a3.load = 1; a3.load_val = 3'd5;
    tick();
    check("ld_gray", a3.gray_out, 3'b111);
    check("ld_bin", a3.bin_out, 5);
    a3.load = 0;
    tick();
    check("ld_step_gray", a3.gray_out, 3'b101);
    check("ld_step_bin", a3.bin_out, 6);

    // 5: at bin 6, reset beats load and en
    reset = 1'b1; a3.load = 1; a3.load_val = 3'd3; a3.en = 1;
    tick();
    check("rst_pri_gray", a3.gray_out, 0);
    check("rst_pri_wrapped", a3.wrapped, 0);
    reset = 1'b0; a3.load = 0; a3.en = 0;

    // 4: saturate mode holds at max, release on direction change
    a4.load = 1; a4.load_val = 4'd15;
    tick();
    a4.load = 0;
    check("sat_ld_gray", a4.gray_out, 4'b1000);
    check("sat_ld_tc", a4.tc, 1);
    a4.en = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("sat_gray%0d", k), a4.gray_out, 4'b1000);
      check($sformatf("sat_tc%0d", k), a4.tc, 1);
      check($sformatf("sat_wrapped%0d", k), a4.wrapped, 0);
    end
    a4.up_dn = 0;
    #1;
    check("sat_tc_dn", a4.tc, 0);
    tick();
    check("sat_dn_gray", a4.gray_out, 4'b1001);
    check("sat_dn_bin", a4.bin_out, 14);
    a4.en = 0;

    // 6: 8-bit random walk against a modulo-256 model, starting near the top
    a8.load = 1; a8.load_val = 8'd250;
    tick();
    a8.load = 0;
    m = 250; mw = 0; seen_w = 0; exp_w = 0;
    check("rw_ld_bin", a8.bin_out, 250);
    for (int k = 0; k < 600; k++) begin
      e = ($urandom_range(0, 9) != 0);
      d = ($urandom_range(0, 9) < 7);
      a8.en = e; a8.up_dn = d;
      prev_g = a8.gray_out;
      exp_w = 0;
      if (e) begin
        if ((d && m == 255) || (!d && m == 0)) begin
          mw++;
          exp_w = 1;
        end
        m = d ? (m + 1) & 255 : (m + 255) & 255;
      end
      tick();
      check("rw_bin", a8.bin_out, m);
      check("rw_gray", a8.gray_out, m ^ (m >> 1));
      check("rw_onebit", $countones(prev_g ^ a8.gray_out), e ? 1 : 0);
      check("rw_wrapped", a8.wrapped, exp_w);
      if (a8.wrapped === 1'b1) seen_w++;
    end
    check("rw_wrap_count", seen_w, mw);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
